// File: rtl/thresh_proc.sv
// Per-pixel threshold pass over a RAM frame; optional above-threshold count under THRESH_STATS_EN.
// Latency: 3 cycles per pixel (read, capture, write); done after 3*PIX_COUNT cycles from start.
// Backpressure: none; the RAM answers one cycle after RAM_ren, and start is ignored mid-frame.
module thresh_proc #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 20,
    parameter int HDR_SIZE  = 54,
    parameter int PIX_COUNT = 262144
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] threshold,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] RAM_out,
    output logic              RAM_ren,
    output logic              RAM_wen,
    output logic [DATA_W-1:0] RAM_in,
    output logic [ADDR_W-1:0] RAM_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] above_cnt
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    localparam logic [ADDR_W-1:0] HDR_A    = ADDR_W'(HDR_SIZE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIX_COUNT - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   thr_q, thr_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                above;
    logic [DATA_W-1:0]   f_pix;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        thr_d   = thr_q;
        mode_d  = mode_q;
        pix_d   = pix_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d = RD;
                    thr_d   = threshold;
                    mode_d  = mode;
                    idx_d   = '0;
                    ren_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                state_d = WR;
                pix_d   = RAM_out;
                wen_d   = 1'b1;
            end
            WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD;
                    idx_d   = idx_q + 1'b1;
                    ren_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            thr_q   <= '0;
            mode_q  <= '0;
            pix_q   <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            mode_q  <= mode_d;
            pix_q   <= pix_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Transfer function sees only the latched pixel/threshold/mode, so RAM_in is stable all of WR.
    assign above = pix_q > thr_q;

    always_comb begin
        f_pix = '0;
        case (mode_q)
            2'b00:   f_pix = above ? '1    : '0;
            2'b01:   f_pix = above ? '0    : '1;
            2'b10:   f_pix = above ? thr_q : pix_q;
            default: f_pix = above ? pix_q : '0;
        endcase
    end

    assign RAM_ren  = ren_q;
    assign RAM_wen  = wen_q;
    assign RAM_in   = wen_q ? f_pix : '0;
    assign RAM_addr = HDR_A + idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef THRESH_STATS_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              frame_start;

    assign frame_start = ((state_q == IDLE) || (state_q == FIN)) && start;

    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = '0;
        end else if ((state_q == WR) && above && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign above_cnt = cnt_q;
`else
    assign above_cnt = '0;
`endif

endmodule
